pipe_skid_stage_reg: RTL and testbench

- Parametrised, elastic successor to the fixed EXE/MEM stage register.
- Carries a control field, two data words and a destination tag between pipeline stages with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput when the downstream stage is ready, and lossless stalling when it is not.
- Adds freeze, flush-to-bubble, an occupancy output and a saturating stall counter for performance debug.

---
 rtl/pipe_skid_stage_reg.sv | 175 +++++++++++++++++
 tb/tb_pipe_skid_stage_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage_reg.sv
// Elastic EXE/MEM stage register with a 2-entry skid buffer.
// Adds freeze, flush-to-bubble, occupancy and a saturating stall counter.
module pipe_skid_stage_reg #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DEST_W-1:0] out_dest,
    input  logic              freeze,
    input  logic              flush,
    input  logic              clr_stats,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data0;
    logic [DATA_W-1:0] main_data1;
    logic [DEST_W-1:0] main_dest;

    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data0;
    logic [DATA_W-1:0] skid_data1;
    logic [DEST_W-1:0] skid_dest;

    logic acc;
    logic con;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid;
    logic stall_inc;
    logic stall_sat;

    assign in_ready  = (state != FULL) & ~freeze & ~flush;
    assign out_valid = (state != EMPTY) & ~freeze & ~flush;
    assign acc       = in_valid & in_ready;
    assign con       = out_valid & out_ready;

    assign out_ctrl  = main_ctrl;
    assign out_data0 = main_data0;
    assign out_data1 = main_data1;
    assign out_dest  = main_dest;

    // State register; reset discards every held entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Next state and register load enables; flush forces a bubble.
    always_comb begin
        state_n      = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state_n    = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && con) begin
                        ld_main_in = 1'b1;
                    end else if (acc) begin
                        state_n = FULL;
                        ld_skid = 1'b1;
                    end else if (con) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (con) begin
                        state_n      = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // Head entry; on flush only the control field is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl  <= '0;
            main_data0 <= '0;
            main_data1 <= '0;
            main_dest  <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
        end else if (ld_main_in) begin
            main_ctrl  <= in_ctrl;
            main_data0 <= in_data0;
            main_data1 <= in_data1;
            main_dest  <= in_dest;
        end else if (ld_main_skid) begin
            main_ctrl  <= skid_ctrl;
            main_data0 <= skid_data0;
            main_data1 <= skid_data1;
            main_dest  <= skid_dest;
        end
    end

    // Skid entry catches the input while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_ctrl  <= '0;
            skid_data0 <= '0;
            skid_data1 <= '0;
            skid_dest  <= '0;
        end else if (ld_skid && !flush) begin
            skid_ctrl  <= in_ctrl;
            skid_data0 <= in_data0;
            skid_data1 <= in_data1;
            skid_dest  <= in_dest;
        end
    end

    // Occupancy decode from the state encoding.
    always_comb begin
        occ = 2'd0;
        unique case (state)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    assign stall_inc = (state != EMPTY) & (freeze | ~out_ready) & ~flush;
    assign stall_sat = &stall_cnt;

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (clr_stats) begin
            stall_cnt <= '0;
        end else if (stall_inc && !stall_sat) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// Scoreboard bench for pipe_skid_stage_reg.
// A queue holds accepted payloads; the head is compared on every cycle.
module tb_pipe_skid_stage_reg;

    localparam int CW  = 3;
    localparam int DW  = 32;
    localparam int TW  = 4;
    localparam int NW  = 4;
    localparam int MAX = 15;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [TW-1:0] t;
    } pl_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data0;
    logic [DW-1:0] in_data1;
    logic [TW-1:0] in_dest;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data0;
    logic [DW-1:0] out_data1;
    logic [TW-1:0] out_dest;
    logic          freeze;
    logic          flush;
    logic          clr_stats;
    logic [1:0]    occ;
    logic [NW-1:0] stall_cnt;

    pl_t q[$];
    int  mcnt;
    bit  ctrl0;
    int  nvec;
    int  nbad;

    pipe_skid_stage_reg #(
        .CTRL_W(CW),
        .DATA_W(DW),
        .DEST_W(TW),
        .CNT_W (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data0 (in_data0),
        .in_data1 (in_data1),
        .in_dest  (in_dest),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data0(out_data0),
        .out_data1(out_data1),
        .out_dest (out_dest),
        .freeze   (freeze),
        .flush    (flush),
        .clr_stats(clr_stats),
        .occ      (occ),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic pl_t mk(input logic [31:0] v);
        pl_t p;
        p.c  = v[CW-1:0];
        p.d0 = v;
        p.d1 = ~v;
        p.t  = v[TW-1:0];
        return p;
    endfunction

    // One cycle: drive at negedge, check at +1, advance model on posedge.
    task automatic cyc(input bit iv, input logic [31:0] v, input bit ordy,
                       input bit frz, input bit fl, input bit clr);
        pl_t p;
        pl_t h;
        bit  er;
        bit  ev;
        bit  a;
        bit  c;
        int  n;
        p         = mk(v);
        in_valid  = iv;
        in_ctrl   = p.c;
        in_data0  = p.d0;
        in_data1  = p.d1;
        in_dest   = p.t;
        out_ready = ordy;
        freeze    = frz;
        flush     = fl;
        clr_stats = clr;
        #1;
        n  = q.size();
        er = (n < 2) && !frz && !fl;
        ev = (n > 0) && !frz && !fl;
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("occ", 64'(occ), 64'(n));
        chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
        if (n > 0) begin
            h = q[0];
            chk("out_ctrl", 64'(out_ctrl), 64'(h.c));
            chk("out_data0", 64'(out_data0), 64'(h.d0));
            chk("out_data1", 64'(out_data1), 64'(h.d1));
            chk("out_dest", 64'(out_dest), 64'(h.t));
        end else if (ctrl0) begin
            chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
        end
        a = iv && er;
        c = ev && ordy;
        @(posedge clk);
        if (clr) begin
            mcnt = 0;
        end else if (n > 0 && (frz || !ordy) && !fl && mcnt < MAX) begin
            mcnt++;
        end
        if (fl) begin
            q.delete();
            ctrl0 = 1'b1;
        end else begin
            if (c) void'(q.pop_front());
            if (a) begin
                q.push_back(p);
                ctrl0 = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        nvec      = 0;
        nbad      = 0;
        mcnt      = 0;
        ctrl0     = 1'b1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data0  = '0;
        in_data1  = '0;
        in_dest   = '0;
        out_ready = 1'b0;
        freeze    = 1'b0;
        flush     = 1'b0;
        clr_stats = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_occ", 64'(occ), 64'(0));
        chk("rst_data0", 64'(out_data0), 64'(0));
        chk("rst_dest", 64'(out_dest), 64'(0));
        chk("rst_stall", 64'(stall_cnt), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= 8; i++) cyc(1, i, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        cyc(1, 32'hA, 0, 0, 0, 0);
        cyc(1, 32'hB, 0, 0, 0, 0);
        cyc(1, 32'hC, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        cyc(0, 0, 1, 0, 0, 1);
        cyc(1, 32'h5, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h9, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        cyc(1, 32'h7, 0, 0, 0, 0);
        cyc(1, 32'h17, 0, 0, 0, 0);
        cyc(1, 32'h27, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 32'h44, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        cyc(0, 0, 1, 0, 0, 1);
        cyc(1, 32'h61, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        cyc(1, 32'h71, 0, 0, 0, 0);
        cyc(1, 32'h72, 0, 0, 0, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_occ", 64'(occ), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        chk("arst_stall", 64'(stall_cnt), 64'(0));
        q.delete();
        mcnt  = 0;
        ctrl0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 32'h99, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
